// File: rtl/load_value_predictor.sv
// -----------------------------------------------------------------------------
// load_value_predictor
//
// PC-indexed, direct-mapped load value predictor for the MEM stage. Each entry
// holds a valid bit, a tag, the last loaded value, a saturating confidence
// counter and, when built with VP_STRIDE_EN, a stride. A prediction is
// forwarded only when the entry hits with enough confidence. The prediction is
// checked against the D-cache response, and a one-cycle recovery request is
// raised on a mismatch. The table trains on every resolved load.
//
// Configuration macro:
//   VP_STRIDE_EN  defined   : stride predictor, P = last + stride
//                 undefined : last-value predictor, P = last
//
// Ports:
//   clk                clock
//   rst_n              asynchronous active-low reset
//   lookup_valid_i     MEM stage presents a load (taken only when ready)
//   lookup_pc_i        PC of the load
//   lookup_ready_o     predictor is idle and can take a lookup
//   flush_i            abort the in-flight load; the table is not updated
//   resp_valid_i       D-cache load data valid (single-cycle pulse)
//   resp_data_i        actual load value
//   recovery_done_i    pipeline finished squash/replay
//   pred_valid_o       speculative value valid (one-cycle pulse)
//   pred_data_o        predicted value; holds while pred_valid_o is low
//   done_o             load resolved, no recovery needed (one-cycle pulse)
//   en_recover_o       forwarded prediction was wrong (one-cycle pulse)
//   busy_o             predictor is not idle
// -----------------------------------------------------------------------------
module load_value_predictor #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int INDEX_WIDTH = 6,
  parameter int CONF_BITS   = 2,
  parameter int CONF_THRESH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  lookup_valid_i,
  input  logic [ADDR_WIDTH-1:0] lookup_pc_i,
  output logic                  lookup_ready_o,
  input  logic                  flush_i,
  input  logic                  resp_valid_i,
  input  logic [DATA_WIDTH-1:0] resp_data_i,
  input  logic                  recovery_done_i,
  output logic                  pred_valid_o,
  output logic [DATA_WIDTH-1:0] pred_data_o,
  output logic                  done_o,
  output logic                  en_recover_o,
  output logic                  busy_o
);

  localparam int ENTRIES   = 1 << INDEX_WIDTH;
  localparam int TAG_WIDTH = ADDR_WIDTH - INDEX_WIDTH - 2;
  localparam logic [CONF_BITS-1:0] CONF_THR = CONF_BITS'(CONF_THRESH);
  localparam logic [CONF_BITS-1:0] CONF_MAX = '1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_TRAIN, S_RECOVER} state_e;

  // Prediction table
  logic [ENTRIES-1:0]    valid_q;
  logic [TAG_WIDTH-1:0]  tag_q  [ENTRIES];
  logic [DATA_WIDTH-1:0] last_q [ENTRIES];
  logic [CONF_BITS-1:0]  conf_q [ENTRIES];
`ifdef VP_STRIDE_EN
  logic [DATA_WIDTH-1:0] stride_q [ENTRIES];
`endif

  // In-flight load context
  state_e                 state_q;
  logic [INDEX_WIDTH-1:0] idx_q;
  logic [TAG_WIDTH-1:0]   tag_lat_q;
  logic [DATA_WIDTH-1:0]  p_q;
  logic                   hit_q;
  logic                   pred_valid_q;
  logic [DATA_WIDTH-1:0]  pred_data_q;
  logic                   done_q;
  logic                   en_recover_q;

  // Lookup side
  logic [INDEX_WIDTH-1:0] lk_idx;
  logic [TAG_WIDTH-1:0]   lk_tag;
  logic                   lk_hit;
  logic                   lk_fwd;
  logic [DATA_WIDTH-1:0]  lk_pred;
  logic                   unused_pc_lsbs;

  assign lk_idx         = lookup_pc_i[INDEX_WIDTH+1:2];
  assign lk_tag         = lookup_pc_i[ADDR_WIDTH-1:INDEX_WIDTH+2];
  assign lk_hit         = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign lk_fwd         = lk_hit && (conf_q[lk_idx] >= CONF_THR);
  assign unused_pc_lsbs = ^lookup_pc_i[1:0];
`ifdef VP_STRIDE_EN
  assign lk_pred = last_q[lk_idx] + stride_q[lk_idx];
`else
  assign lk_pred = last_q[lk_idx];
`endif

  // Resolve side: the entry at idx_q cannot change while a load is in flight,
  // so reading it at response time sees the same contents as at lookup.
  logic                  tbl_we;
  logic                  resp_match;
  logic [CONF_BITS-1:0]  conf_new;

  assign tbl_we     = ((state_q == S_WAIT) || (state_q == S_TRAIN)) &&
                      resp_valid_i && !flush_i;
  assign resp_match = (resp_data_i == p_q);

  always_comb begin
    conf_new = '0;
    if (hit_q && resp_match)
      conf_new = (conf_q[idx_q] == CONF_MAX) ? CONF_MAX : conf_q[idx_q] + 1'b1;
  end

  // Valid bits are the only table state that needs a reset: every other field
  // is written before its entry becomes valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (tbl_we) begin
      valid_q[idx_q] <= 1'b1;
    end
  end

  // NOTE: table payload arrays are deliberately left without reset so they map
  // onto plain storage; the valid bits alone make stale contents harmless.
  always_ff @(posedge clk) begin
    if (tbl_we) begin
      tag_q[idx_q]  <= tag_lat_q;
      last_q[idx_q] <= resp_data_i;
      conf_q[idx_q] <= conf_new;
`ifdef VP_STRIDE_EN
      if (!hit_q)
        stride_q[idx_q] <= '0;
      else if (!resp_match)
        stride_q[idx_q] <= resp_data_i - last_q[idx_q];
`endif
    end
  end

  // Control FSM with registered pulse outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      tag_lat_q    <= '0;
      p_q          <= '0;
      hit_q        <= 1'b0;
      pred_valid_q <= 1'b0;
      pred_data_q  <= '0;
      done_q       <= 1'b0;
      en_recover_q <= 1'b0;
    end else begin
      pred_valid_q <= 1'b0;
      done_q       <= 1'b0;
      en_recover_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (lookup_valid_i) begin
            idx_q     <= lk_idx;
            tag_lat_q <= lk_tag;
            p_q       <= lk_pred;
            hit_q     <= lk_hit;
            if (lk_fwd) begin
              state_q      <= S_WAIT;
              pred_valid_q <= 1'b1;
              pred_data_q  <= lk_pred;
            end else begin
              state_q <= S_TRAIN;
            end
          end
        end
        S_WAIT: begin
          if (flush_i) begin
            state_q <= S_IDLE;
          end else if (resp_valid_i) begin
            if (resp_match) begin
              done_q  <= 1'b1;
              state_q <= S_IDLE;
            end else begin
              en_recover_q <= 1'b1;
              state_q      <= S_RECOVER;
            end
          end
        end
        S_TRAIN: begin
          if (flush_i) begin
            state_q <= S_IDLE;
          end else if (resp_valid_i) begin
            done_q  <= 1'b1;
            state_q <= S_IDLE;
          end
        end
        S_RECOVER: begin
          if (recovery_done_i) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign lookup_ready_o = (state_q == S_IDLE);
  assign busy_o         = (state_q != S_IDLE);
  assign pred_valid_o   = pred_valid_q;
  assign pred_data_o    = pred_data_q;
  assign done_o         = done_q;
  assign en_recover_o   = en_recover_q;

endmodule
